result_writeback_buffer: RTL and testbench

- Write-side counterpart of the operand memory buffer.
- Accepts a write command: base RAM address plus row count. Collects N-wide result rows from the processing units over valid/ready with a last flag, and writes them to RAM one row per memory write handshake at consecutive addresses.
- A small FIFO decouples processing-unit output from memory backpressure.
- Pulses done once every row of the command has been written, then waits for the next command.

---
 rtl/result_writeback_buffer.sv | 131 +++++++++++++
 tb/tb_result_writeback_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_writeback_buffer.sv
// Result write-back buffer: gathers N-wide result rows from the processing units into a
// small FIFO and writes them to RAM at consecutive row addresses, pulsing done per command.
//
// state  | meaning
// IDLE   | waiting for a write command
// ACTIVE | accepting result rows, writes already draining
// DRAIN  | all rows collected, finishing outstanding writes
// DONE   | one-cycle done pulse being issued
module result_writeback_buffer #(
    parameter int DATA_WIDTH          = 32,
    parameter int N                   = 4,
    parameter int MEMORY_ADDRESS_BITS = 64,
    parameter int MAX_MATRIX_LENGTH   = 4096,
    parameter int COUNTER_BITS        = $clog2(MAX_MATRIX_LENGTH + 1),
    parameter int FIFO_DEPTH          = 4,
    parameter int ROW_STRIDE_BYTES    = N * DATA_WIDTH / 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                address_valid,
    output logic                                address_ready,
    input  logic [MEMORY_ADDRESS_BITS-1:0]      address_input,
    input  logic [COUNTER_BITS-1:0]             length_input,
    input  logic                                result_valid,
    output logic                                result_ready,
    input  logic [N-1:0][DATA_WIDTH-1:0]        result_data,
    input  logic                                result_last,
    output logic                                mem_write_valid,
    input  logic                                mem_write_ready,
    output logic [MEMORY_ADDRESS_BITS-1:0]      mem_write_address,
    output logic [N-1:0][DATA_WIDTH-1:0]        mem_write_data,
    output logic                                done,
    output logic                                last_error
);

    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int PW       = PTR_BITS + 1;
    localparam logic [MEMORY_ADDRESS_BITS-1:0] STRIDE = MEMORY_ADDRESS_BITS'(ROW_STRIDE_BYTES);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

    state_t                             state_q;
    logic [MEMORY_ADDRESS_BITS-1:0]     base_q;
    logic [COUNTER_BITS-1:0]            length_q;
    logic [COUNTER_BITS-1:0]            in_count_q, in_count_d;
    logic [COUNTER_BITS-1:0]            out_count_q, out_count_d;
    logic [PW-1:0]                      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                      rd_ptr_q, rd_ptr_d;
    logic                               done_q;
    logic                               last_error_q;
    logic [N-1:0][DATA_WIDTH-1:0]       fifo_mem_q [FIFO_DEPTH];

    logic fifo_empty, fifo_full, writing, cmd_fire, push, pop, last_row;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                        (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);
    assign writing    = (state_q == ACTIVE) || (state_q == DRAIN);

    assign address_ready   = (state_q == IDLE);
    assign result_ready    = (state_q == ACTIVE) && !fifo_full && (in_count_q < length_q);
    assign mem_write_valid = writing && !fifo_empty;
    assign mem_write_data  = mem_write_valid ? fifo_mem_q[rd_ptr_q[PTR_BITS-1:0]] : '0;
    assign mem_write_address = base_q + MEMORY_ADDRESS_BITS'(out_count_q) * STRIDE;
    assign done       = done_q;
    assign last_error = last_error_q;

    assign cmd_fire = address_valid && address_ready;
    assign push     = result_valid && result_ready;
    assign pop      = mem_write_valid && mem_write_ready;
    assign last_row = (in_count_q == (length_q - COUNTER_BITS'(1)));

    assign in_count_d  = in_count_q + COUNTER_BITS'(push);
    assign out_count_d = out_count_q + COUNTER_BITS'(pop);
    assign wr_ptr_d    = wr_ptr_q + PW'(push);
    assign rd_ptr_d    = rd_ptr_q + PW'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            length_q     <= '0;
            in_count_q   <= '0;
            out_count_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            done_q       <= 1'b0;
            last_error_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_count_q  <= in_count_d;
            out_count_q <= out_count_d;
            case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        base_q       <= address_input;
                        length_q     <= length_input;
                        in_count_q   <= '0;
                        out_count_q  <= '0;
                        last_error_q <= 1'b0;
                        state_q      <= (length_input == '0) ? DONE : ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (push && (result_last != last_row))
                        last_error_q <= 1'b1;
                    if (in_count_d == length_q)
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    if (out_count_d == length_q)
                        state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem_q[wr_ptr_q[PTR_BITS-1:0]] <= result_data;
    end

endmodule

// File: tb/tb_result_writeback_buffer.sv
// Self-checking bench for result_writeback_buffer: a command table drives rows and RAM
// backpressure, a scoreboard queue holds the expected writes, hand sequences cover reset.
module tb_result_writeback_buffer;

    localparam int DW     = 32;
    localparam int N      = 4;
    localparam int AW     = 64;
    localparam int CB     = 13;
    localparam int STRIDE = N * DW / 8;

    typedef logic [N-1:0][DW-1:0] row_t;
    typedef struct {
        logic [AW-1:0] addr;
        row_t          data;
    } wr_t;
    typedef struct {
        logic [AW-1:0] addr;
        int            len;
        int            last_idx;
        int            stall;
        bit            seq_data;
        bit            chk_full;
        bit            exp_err;
    } case_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            address_valid;
    logic            address_ready;
    logic [AW-1:0]   address_input;
    logic [CB-1:0]   length_input;
    logic            result_valid;
    logic            result_ready;
    row_t            result_data;
    logic            result_last;
    logic            mem_write_valid;
    logic            mem_write_ready;
    logic [AW-1:0]   mem_write_address;
    row_t            mem_write_data;
    logic            done;
    logic            last_error;

    result_writeback_buffer dut (
        .clk               (clk),
        .reset             (reset),
        .address_valid     (address_valid),
        .address_ready     (address_ready),
        .address_input     (address_input),
        .length_input      (length_input),
        .result_valid      (result_valid),
        .result_ready      (result_ready),
        .result_data       (result_data),
        .result_last       (result_last),
        .mem_write_valid   (mem_write_valid),
        .mem_write_ready   (mem_write_ready),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .done              (done),
        .last_error        (last_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  rows_acc;
    case_t cases[6];

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    // Called at a negedge; returns at the negedge after the command is accepted.
    task automatic send_cmd(logic [AW-1:0] a, int len, output int acc_cyc);
        address_valid = 1'b1;
        address_input = a;
        length_input  = CB'(len);
        for (int w = 0; w < 50 && !address_ready; w++) @(negedge clk);
        if (!address_ready) timeout("cmd_accept");
        acc_cyc = cyc;
        @(negedge clk);
        address_valid = 1'b0;
    endtask

    task automatic offer_row(row_t d, bit last, bit track, logic [AW-1:0] exp_addr, output bit ok);
        ok = 1'b0;
        result_valid = 1'b1;
        result_data  = d;
        result_last  = last;
        for (int w = 0; w < 300; w++) begin
            if (result_ready) begin
                if (track) exp_q.push_back('{addr: exp_addr, data: d});
                rows_acc++;
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        result_valid = 1'b0;
        result_last  = 1'b0;
        if (!ok) timeout("row_accept");
    endtask

    task automatic run_case(case_t c);
        int acc, done_cyc;
        bit saw_rr, fin;
        send_cmd(c.addr, c.len, acc);
        check("err_clear", last_error, 0);
        rows_acc = 0;
        done_cyc = -1;
        saw_rr = 1'b0;
        fin = 1'b0;
        fork
            begin
                for (int r = 0; r < c.len; r++) begin
                    row_t d;
                    bit ok;
                    for (int e = 0; e < N; e++)
                        d[e] = c.seq_data ? DW'(r * N + e + 1) : DW'($urandom);
                    offer_row(d, (r == c.last_idx), 1'b1, c.addr + AW'(r) * AW'(STRIDE), ok);
                    if (!ok) break;
                end
            end
            begin
                for (int i = 0; i < 400; i++) begin
                    mem_write_ready = (i >= c.stall);
                    if (result_ready) saw_rr = 1'b1;
                    if (c.chk_full && i == c.stall - 1) begin
                        check("bp_rows_accepted", rows_acc, 4);
                        check("bp_ready_low", result_ready, 0);
                    end
                    if (done) begin
                        done_cyc = cyc;
                        fin = 1'b1;
                        break;
                    end
                    if (mem_write_valid && mem_write_ready) begin
                        if (exp_q.size() == 0) begin
                            timeout("extra_write");
                        end else begin
                            wr_t e;
                            e = exp_q.pop_front();
                            check("wr_addr", mem_write_address, e.addr);
                            check("wr_data", mem_write_data, e.data);
                        end
                    end
                    @(negedge clk);
                end
                if (!fin) timeout("done_wait");
            end
        join
        check("sb_empty", exp_q.size(), 0);
        check("last_error", last_error, c.exp_err);
        if (c.len == 0) begin
            check("zero_done_latency", done_cyc - acc, 2);
            check("zero_no_ready", saw_rr, 0);
        end
        @(negedge clk);
        check("done_single_pulse", done, 0);
    endtask

    initial begin
        case_t post;
        int acc;
        bit ok;
        row_t d;
        reset = 1'b1;
        address_valid = 1'b0;
        address_input = '0;
        length_input = '0;
        result_valid = 1'b0;
        result_data = '0;
        result_last = 1'b0;
        mem_write_ready = 1'b0;

        cases[0] = '{addr: 64'h1000, len: 3, last_idx: 2, stall: 0, seq_data: 1, chk_full: 0, exp_err: 0};
        cases[1] = '{addr: 64'h8000, len: 8, last_idx: 7, stall: 10, seq_data: 0, chk_full: 1, exp_err: 0};
        cases[2] = '{addr: 64'h4000, len: 4, last_idx: 1, stall: 0, seq_data: 0, chk_full: 0, exp_err: 1};
        cases[3] = '{addr: 64'h5000, len: 5, last_idx: 4, stall: 3, seq_data: 0, chk_full: 0, exp_err: 0};
        cases[4] = '{addr: 64'h9000, len: 0, last_idx: -1, stall: 0, seq_data: 0, chk_full: 0, exp_err: 0};
        cases[5] = '{addr: 64'hFFFF_FFFF_FFFF_FFF0, len: 2, last_idx: 1, stall: 1, seq_data: 0, chk_full: 0, exp_err: 0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_flags", {address_ready, result_ready, mem_write_valid, done, last_error}, 5'b10000);
        check("rst_addr", mem_write_address, 0);
        check("rst_data", mem_write_data, 0);

        for (int k = 0; k < 6; k++) run_case(cases[k]);

        // Reset mid-command: 3 rows in (first one wrongly marked last), 1 written, then reset.
        send_cmd(64'h3000, 6, acc);
        mem_write_ready = 1'b0;
        rows_acc = 0;
        for (int r = 0; r < 3; r++) begin
            for (int e = 0; e < N; e++) d[e] = DW'($urandom);
            offer_row(d, (r == 0), 1'b0, '0, ok);
        end
        check("mid_rows_accepted", rows_acc, 3);
        check("mid_last_error", last_error, 1);
        mem_write_ready = 1'b1;
        @(negedge clk);
        mem_write_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_flags", {address_ready, result_ready, mem_write_valid, done, last_error}, 5'b10000);
        check("mid_rst_addr", mem_write_address, 0);
        check("mid_rst_data", mem_write_data, 0);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        post = '{addr: 64'h2000, len: 1, last_idx: 0, stall: 0, seq_data: 0, chk_full: 0, exp_err: 0};
        run_case(post);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
